// File: rtl/freq_pkg.sv
// ----------------------------------------------------------------------------
// freq_pkg
// Shared definitions for the run-length bit-stream link (transmitter and
// run detector). A data bit is a run of ones closed by a single zero; the
// run length encodes the bit value.
//   freq_tx_state_t : transmitter FSM states
//   RUN_SHORT       : run length carrying a 0 bit
//   RUN_LONG        : run length carrying a 1 bit
//   run_len()       : bit value -> run length
// ----------------------------------------------------------------------------
package freq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONES = 2'd1,
        TERM = 2'd2,
        GAP  = 2'd3
    } freq_tx_state_t;

    localparam logic [2:0] RUN_SHORT = 3'd2;
    localparam logic [2:0] RUN_LONG  = 3'd4;

    function automatic logic [2:0] run_len(input logic b);
        return b ? RUN_LONG : RUN_SHORT;
    endfunction

endpackage

// File: rtl/freq_tx.sv
// ----------------------------------------------------------------------------
// freq_tx
// Run-length symbol transmitter. Accepts a WIDTH-bit word over valid/ready
// and sends it MSB first: each bit is a run of ones (2 for a 0, 4 for a 1)
// followed by one zero, then IDLE_ZEROS padding zeros after the word.
//   clock      : rising-edge clock
//   reset      : asynchronous, active-low
//   sym_valid  : word offered on sym_data
//   sym_data   : word to transmit (WIDTH bits)
//   sym_ready  : high only while idle, word accepted on valid && ready
//   output_bit : registered serial stream, idles at 0
//   busy       : high whenever a word is in flight (not idle)
//   done       : high in the cycle the last terminating zero is driven
// ----------------------------------------------------------------------------
module freq_tx
    import freq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int IDLE_ZEROS = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sym_valid,
    input  logic [WIDTH-1:0] sym_data,
    output logic             sym_ready,
    output logic             output_bit,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W    = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_LEN  = 4'(IDLE_ZEROS);

    freq_tx_state_t   state;
    logic [2:0]       run_cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [3:0]       gap_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             accept;

    assign sym_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = sym_valid && sym_ready;

    // Control path: FSM, counters and the registered serial output.
    // run_cnt counts ones already driven, so it is loaded with 1 on the
    // edge that starts a run and compared against the target before
    // incrementing; it therefore tops out at RUN_LONG.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            run_cnt    <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            output_bit <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    output_bit <= 1'b0;
                    done       <= 1'b0;
                    if (accept) begin
                        state      <= ONES;
                        run_cnt    <= 3'd1;
                        bit_idx    <= IDX_LAST;
                        output_bit <= 1'b1;
                    end
                end
                ONES: begin
                    if (run_cnt == run_len(shift_reg[WIDTH-1])) begin
                        state      <= TERM;
                        output_bit <= 1'b0;
                        done       <= (bit_idx == '0);
                    end else begin
                        run_cnt    <= run_cnt + 3'd1;
                        output_bit <= 1'b1;
                    end
                end
                TERM: begin
                    done    <= 1'b0;
                    run_cnt <= '0;
                    if (bit_idx != '0) begin
                        bit_idx    <= bit_idx - IDX_W'(1);
                        run_cnt    <= 3'd1;
                        output_bit <= 1'b1;
                        state      <= ONES;
                    end else if (GAP_LEN == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= 4'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LEN) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    output_bit <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    // Data path: captured word, shifted left as each terminator is sent so
    // the bit being encoded is always the MSB. Only loaded on a handshake,
    // so later changes on sym_data cannot disturb a word in flight.
    always_ff @(posedge clock) begin
        if (accept) begin
            shift_reg <= sym_data;
        end else if (state == TERM) begin
            shift_reg <= shift_reg << 1;
        end
    end

endmodule
